ibfu_pipe: RTL



---
 rtl/ibfu_pipe.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ibfu_pipe.sv
// ibfu_pipe: pipelined inverse radix-2 DIT butterfly for the IFFT path.
// Recovers Xa = (Ya + Yb)/2 and Xb = ((Ya - Yb)/2) * conj(W) in Q1.14.
// Three register stages (S1 add/halve, S2 conj multiply + round, S3 range
// limit) advance together under a single stall signal from the output side.
// Build option: define IBFU_SAT_EN to clamp Xb to DW bits and track
// saturation in ovf_sticky; otherwise Xb wraps and ovf_sticky is 0.
module ibfu_pipe #(
  parameter int DW   = 16,
  parameter int FRAC = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] Yar,
  input  logic [DW-1:0] Yai,
  input  logic [DW-1:0] Ybr,
  input  logic [DW-1:0] Ybi,
  input  logic [DW-1:0] Wr,
  input  logic [DW-1:0] Wi,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] Xar,
  output logic [DW-1:0] Xai,
  output logic [DW-1:0] Xbr,
  output logic [DW-1:0] Xbi,
  output logic          ovf_sticky
);

  localparam int PW = 2 * DW;       // product width
  localparam int AW = 2 * DW + 1;   // accumulator width
  localparam int RW = AW - FRAC;    // width after the rounding shift
  localparam logic [AW-1:0] RND = AW'(1) << (FRAC - 1);

  logic advance;
  logic v1, v2;

  // The whole pipe moves unless a valid output is being held back.
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // S1 inputs: sums/differences at DW+1 bits, then halved by dropping the LSB.
  logic [DW:0] sum_r, sum_i, dif_r, dif_i;
  assign sum_r = {Yar[DW-1], Yar} + {Ybr[DW-1], Ybr};
  assign sum_i = {Yai[DW-1], Yai} + {Ybi[DW-1], Ybi};
  assign dif_r = {Yar[DW-1], Yar} - {Ybr[DW-1], Ybr};
  assign dif_i = {Yai[DW-1], Yai} - {Ybi[DW-1], Ybi};

  logic        [DW-1:0] xar1, xai1, xar2, xai2;
  logic signed [DW-1:0] dr1, di1, wr1, wi1;

  // Stage valid bits: the only pipeline state that must be cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  // S1 data register: halved sum/difference plus the beat's own twiddle.
  // NOTE: datapath registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (advance) begin
      xar1 <= sum_r[DW:1];
      xai1 <= sum_i[DW:1];
      dr1  <= dif_r[DW:1];
      di1  <= dif_i[DW:1];
      wr1  <= Wr;
      wi1  <= Wi;
    end
  end

  // S2 inputs: conj multiply (dr + j di)(wr - j wi) with half-up rounding.
  logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri;
  logic        [AW-1:0] acc_re, acc_im;
  assign p_rr   = PW'(dr1) * PW'(wr1);
  assign p_ii   = PW'(di1) * PW'(wi1);
  assign p_ir   = PW'(di1) * PW'(wr1);
  assign p_ri   = PW'(dr1) * PW'(wi1);
  assign acc_re = AW'(p_rr) + AW'(p_ii) + RND;
  assign acc_im = AW'(p_ir) - AW'(p_ri) + RND;

  logic signed [RW-1:0] re2, im2;

  // S2 data register: Xa passes through, Xb is the rounded Q1.14 product.
  always_ff @(posedge clk) begin
    if (advance) begin
      xar2 <= xar1;
      xai2 <= xai1;
      re2  <= acc_re[AW-1:FRAC];
      im2  <= acc_im[AW-1:FRAC];
    end
  end

  logic [DW-1:0] xbr_n, xbi_n;

`ifdef IBFU_SAT_EN
  localparam logic signed [RW-1:0] MAXV = RW'((2 ** (DW - 1)) - 1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  logic sat_hit;

  // S3 range limit: clamp each Xb component and flag any clamp.
  // NOTE: defaults first so every path assigns every output (no latch).
  always_comb begin
    sat_hit = 1'b0;
    xbr_n   = re2[DW-1:0];
    xbi_n   = im2[DW-1:0];
    if (re2 > MAXV) begin
      xbr_n   = MAXV[DW-1:0];
      sat_hit = 1'b1;
    end else if (re2 < MINV) begin
      xbr_n   = MINV[DW-1:0];
      sat_hit = 1'b1;
    end
    if (im2 > MAXV) begin
      xbi_n   = MAXV[DW-1:0];
      sat_hit = 1'b1;
    end else if (im2 < MINV) begin
      xbi_n   = MINV[DW-1:0];
      sat_hit = 1'b1;
    end
  end

  // Sticky overflow flag, set as the saturated beat lands in S3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        ovf_sticky <= 1'b0;
    else if (advance & v2 & sat_hit) ovf_sticky <= 1'b1;
  end
`else
  // S3 range limit: keep the low DW bits (two's-complement wrap).
  always_comb begin
    xbr_n = re2[DW-1:0];
    xbi_n = im2[DW-1:0];
  end

  logic unused_hi;
  assign unused_hi  = ^{re2[RW-1:DW], im2[RW-1:DW]};
  assign ovf_sticky = 1'b0;
`endif

  // S3 output register: loads only real beats so outputs stay 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Xar <= '0;
      Xai <= '0;
      Xbr <= '0;
      Xbi <= '0;
    end else if (advance & v2) begin
      Xar <= xar2;
      Xai <= xai2;
      Xbr <= xbr_n;
      Xbi <= xbi_n;
    end
  end

endmodule
